// File: rtl/instr_enc_if.sv
// Request/response stream bundle between an instruction producer and the encoder.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_expand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic [1:0]  out_err;

  // Producer side: drives requests, consumes encoded words.
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_expand, out_ready,
    input  in_ready, out_valid, out_instr, out_last, out_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_expand, out_ready,
    output in_ready, out_valid, out_instr, out_last, out_err
  );
endinterface

// File: rtl/instruction_encoder.sv
// RV32I instruction assembler: scatters immediate bits per format, flags range and
// alignment errors, and optionally splits a wide I-type immediate into LUI + I-type.
module instruction_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_enc_if.slave           bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {EMPTY, FULL, HI, LO} state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic                 last_q, last_d;
  logic [1:0]           err_q, err_d;
  logic [31:0]          pend_q, pend_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] enc_word;
  logic [31:0] enc_lo;
  logic [31:0] imm_rnd;
  logic [1:0]  enc_err;
  logic        enc_exp;
  logic        fits12, fits13, fits21;
  logic        accept;

  logic [31:0] imm;
  assign imm     = bus.in_imm;
  assign fits12  = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13  = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21  = (imm[31:20] == '0) || (imm[31:20] == '1);
  assign imm_rnd = imm + 32'h0000_0800;

  // Format-specific encoding of the incoming request and its error classification.
  always_comb begin
    enc_word = '0;
    enc_err  = 2'b00;
    enc_exp  = 1'b0;
    enc_lo   = {imm[11:0], bus.in_rd, bus.in_funct3, bus.in_rd, bus.in_opcode};
    unique case (bus.in_fmt)
      3'b000: begin
        enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
        if (imm[11:0] != '0) enc_err = 2'b01;
      end
      3'b001: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        if (imm[0])       enc_err = 2'b10;
        else if (!fits21) enc_err = 2'b01;
      end
      3'b010: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        if (!fits12) enc_err = 2'b01;
      end
      3'b011: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], bus.in_opcode};
        if (imm[0])       enc_err = 2'b10;
        else if (!fits13) enc_err = 2'b01;
      end
      3'b100: begin
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        if (!fits12) begin
          if (!bus.in_expand)       enc_err = 2'b01;
          else if (bus.in_rd == '0) enc_err = 2'b11;
          else begin
            enc_exp  = 1'b1;
            enc_word = {imm_rnd[31:12], bus.in_rd, OP_LUI};
          end
        end
      end
      3'b101: begin
        enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        if (imm[31:5] != '0) enc_err = 2'b01;
      end
      3'b110: begin
        enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        if (imm[31:12] != '0) enc_err = 2'b01;
      end
      default: begin
        enc_word = '0;
        enc_err  = 2'b11;
      end
    endcase
  end

  assign bus.in_ready = (state_q == EMPTY) ||
                        (((state_q == FULL) || (state_q == LO)) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Next-state, output-register and error-counter updates.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (accept) begin
      instr_d = enc_word;
      err_d   = enc_err;
      last_d  = !enc_exp;
      pend_d  = enc_lo;
      state_d = enc_exp ? HI : FULL;
      if ((enc_err != 2'b00) && (cnt_q != '1)) cnt_d = cnt_q + ERR_CNT_W'(1);
    end else begin
      unique case (state_q)
        HI: begin
          if (bus.out_ready) begin
            instr_d = pend_q;
            err_d   = 2'b00;
            last_d  = 1'b1;
            state_d = LO;
          end
        end
        FULL, LO: begin
          if (bus.out_ready) state_d = EMPTY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 2'b00;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_instr = instr_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed expected words.
module tb_instruction_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_count;
  int          errors;
  int          checks;

  instr_enc_if bus ();

  instruction_encoder #(.ERR_CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] f7, input logic [31:0] imm, input logic expand);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_funct3 = f3;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_expand = expand;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] instr,
                            input logic [1:0] err, input logic last);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".instr"}, bus.out_instr, instr);
    check({tag, ".err"}, 32'(bus.out_err), 32'(err));
    check({tag, ".last"}, 32'(bus.out_last), 32'(last));
  endtask

  logic [31:0] b2b_word [4];

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.out_ready = 1'b1;
    send(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 1'b0);
    idle();
    #23;
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.instr", bus.out_instr, 32'd0);
    check("rst.last", 32'(bus.out_last), 32'd0);
    check("rst.err", 32'(bus.out_err), 32'd0);
    check("rst.cnt", 32'(err_count), 32'd0);
    check("rst.ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addi x5, x6, -1
    send(3'd4, 7'h13, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    check_word("addi", 32'hFFF3_0293, 2'b00, 1'b1);
    idle();
    tick();
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    // beq x1, x2, +8
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0);
    tick();
    check_word("beq", 32'h0020_8463, 2'b00, 1'b1);
    idle();
    tick();

    // LUI + ADDI expansion, downstream stalled on the first half
    bus.out_ready = 1'b0;
    send(3'd4, 7'h13, 5'd10, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5FFF, 1'b1);
    tick();
    idle();
    check_word("exp.hi", 32'h1234_6537, 2'b00, 1'b0);
    check("exp.hi.ready0", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("exp.hi.ready1", 32'(bus.in_ready), 32'd0);
    tick();
    check_word("exp.lo", 32'hFFF5_0513, 2'b00, 1'b1);
    check("exp.cnt", 32'(err_count), 32'd0);
    tick();
    check("exp.drain", 32'(bus.out_valid), 32'd0);

    // jal x1 with odd offset: misaligned, held under back-pressure
    bus.out_ready = 1'b0;
    send(3'd1, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 1'b0);
    tick();
    idle();
    check_word("jal", 32'h0020_00EF, 2'b10, 1'b1);
    check("jal.cnt", 32'(err_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d.valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d.instr", i), bus.out_instr, 32'h0020_00EF);
    end
    bus.out_ready = 1'b1;
    tick();
    check("jal.drain", 32'(bus.out_valid), 32'd0);

    // illegal format
    send(3'd7, 7'h13, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd5, 1'b0);
    tick();
    idle();
    check_word("ill", 32'h0000_0000, 2'b11, 1'b1);
    check("ill.cnt", 32'(err_count), 32'd2);
    tick();

    // back-to-back: lui, sw, slli, ori
    b2b_word[0] = 32'hABCD_E1B7;
    b2b_word[1] = 32'h0051_2623;
    b2b_word[2] = 32'h0033_9393;
    b2b_word[3] = 32'hFFF2_6213;
    send(3'd0, 7'h37, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCD_E000, 1'b0);
    tick();
    check_word("b2b0", b2b_word[0], 2'b00, 1'b1);
    check("b2b0.ready", 32'(bus.in_ready), 32'd1);
    send(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'd12, 1'b0);
    tick();
    check_word("b2b1", b2b_word[1], 2'b00, 1'b1);
    send(3'd5, 7'h13, 5'd7, 3'd1, 5'd7, 5'd0, 7'd0, 32'd3, 1'b0);
    tick();
    check_word("b2b2", b2b_word[2], 2'b00, 1'b1);
    send(3'd6, 7'h13, 5'd4, 3'd6, 5'd4, 5'd0, 7'd0, 32'h0000_0FFF, 1'b0);
    tick();
    check_word("b2b3", b2b_word[3], 2'b00, 1'b1);
    idle();
    tick();
    check("b2b.drain", 32'(bus.out_valid), 32'd0);

    // range and boundary cases
    send(3'd0, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0001, 1'b0);
    tick();
    check_word("u.range", 32'h0000_00B7, 2'b01, 1'b1);
    send(3'd4, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 1'b0);
    tick();
    check_word("i.range", 32'h8000_0093, 2'b01, 1'b1);
    send(3'd4, 7'h13, 5'd0, 3'd0, 5'd1, 5'd0, 7'd0, 32'h0000_1000, 1'b1);
    tick();
    check_word("i.rd0", 32'h0000_8013, 2'b11, 1'b1);
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_1000, 1'b0);
    tick();
    check_word("b.range", 32'h8000_0063, 2'b01, 1'b1);
    send(3'd5, 7'h13, 5'd1, 3'd1, 5'd1, 5'd0, 7'd0, 32'd32, 1'b0);
    tick();
    check_word("sh.range", 32'h0000_9093, 2'b01, 1'b1);
    send(3'd4, 7'h13, 5'd5, 3'd0, 5'd5, 5'd0, 7'd0, 32'hFFFF_F800, 1'b1);
    tick();
    check_word("i.min", 32'h8002_8293, 2'b00, 1'b1);
    check("range.cnt", 32'(err_count), 32'd7);
    idle();
    tick();

    // reset while the LUI half is held
    bus.out_ready = 1'b0;
    send(3'd4, 7'h13, 5'd10, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5FFF, 1'b1);
    tick();
    idle();
    check("rhi.last", 32'(bus.out_last), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rhi.valid", 32'(bus.out_valid), 32'd0);
    check("rhi.cnt", 32'(err_count), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rhi.post%0d", i), 32'(bus.out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
